// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in a dividend bit, subtract divisor if it fits.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the owner FSM.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    // The shifted partial remainder needs one extra bit: with a divisor above
    // 2^(WIDTH-1) the running remainder can already use the top bit.
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Compare-and-restore; diff fits WIDTH bits because rem_i < dvs_i holds.
    always_comb begin
        shifted = {rem_i, dvd_msb_i};
        diff    = shifted[WIDTH-1:0] - dvs_i;
        q_bit_o = (shifted >= {1'b0, dvs_i});
        rem_o   = q_bit_o ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/iter_div_unit.sv
// Radix-2 restoring divider (signed/unsigned quotient+remainder); optional early out via DIV_EARLY_OUT_EN.
// Latency: accept at T, io_out_valid at T+WIDTH+1 (T+1 for /0 or |src1|<|src2| when DIV_EARLY_OUT_EN).
// Backpressure: io_in_ready only in IDLE; DONE holds the result until io_out_ready; flush aborts anywhere.
module iter_div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic             io_in_bits_ctrl_flow_div_signed,
    input  logic             io_in_bits_ctrl_flow_flush,
    input  logic [WIDTH-1:0] io_in_bits_ctrl_data_src1,
    input  logic [WIDTH-1:0] io_in_bits_ctrl_data_src2,
    input  logic             io_out_ready,
    output logic             io_out_valid,
    output logic [WIDTH-1:0] io_out_bits_result_quotient,
    output logic [WIDTH-1:0] io_out_bits_result_remainder
);

    localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvd_q;      // dividend magnitude; quotient bits shift in from the bottom
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic             q_neg_q;
    logic             r_neg_q;
    logic [WIDTH-1:0] quo_out_q;
    logic [WIDTH-1:0] rem_out_q;
    logic             out_vld_q;

    logic             src1_neg;
    logic             src2_neg;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic             dvs_zero;
    logic [WIDTH-1:0] rem_d;
    logic             q_bit;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] quo_fix_d;
    logic [WIDTH-1:0] rem_fix_d;

    // Operand magnitudes and sign flags, only consumed on the accept cycle.
    always_comb begin
        src1_neg = io_in_bits_ctrl_flow_div_signed & io_in_bits_ctrl_data_src1[WIDTH-1];
        src2_neg = io_in_bits_ctrl_flow_div_signed & io_in_bits_ctrl_data_src2[WIDTH-1];
        abs1     = src1_neg ? (~io_in_bits_ctrl_data_src1 + 1'b1) : io_in_bits_ctrl_data_src1;
        abs2     = src2_neg ? (~io_in_bits_ctrl_data_src2 + 1'b1) : io_in_bits_ctrl_data_src2;
        dvs_zero = (io_in_bits_ctrl_data_src2 == '0);
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (rem_d),
        .q_bit_o   (q_bit)
    );

    // Quotient after this step and the sign-corrected final values for the last step.
    // A zero remainder negates to zero, so it never comes out negative.
    always_comb begin
        quo_d     = {dvd_q[WIDTH-2:0], q_bit};
        quo_fix_d = q_neg_q ? (~quo_d + 1'b1) : quo_d;
        rem_fix_d = r_neg_q ? (~rem_d + 1'b1) : rem_d;
    end

    // Control FSM plus all datapath registers; flush overrides every state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            out_vld_q <= 1'b0;
        end else if (io_in_bits_ctrl_flow_flush) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io_in_valid) begin
                        dvd_q   <= abs1;
                        dvs_q   <= abs2;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        // Divide by zero: the iterations already yield an all-ones
                        // quotient, so its sign fix is suppressed; the remainder
                        // negated back by the dividend sign is exactly src1.
                        q_neg_q <= io_in_bits_ctrl_flow_div_signed & ~dvs_zero &
                                   (io_in_bits_ctrl_data_src1[WIDTH-1] ^ io_in_bits_ctrl_data_src2[WIDTH-1]);
                        r_neg_q <= src1_neg;
`ifdef DIV_EARLY_OUT_EN
                        if (dvs_zero || (abs1 < abs2)) begin
                            quo_out_q <= dvs_zero ? '1 : '0;
                            rem_out_q <= io_in_bits_ctrl_data_src1;
                            out_vld_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            state_q <= BUSY;
                        end
`else
                        state_q <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    rem_q <= rem_d;
                    dvd_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        quo_out_q <= quo_fix_d;
                        rem_out_q <= rem_fix_d;
                        out_vld_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    // Always pass through IDLE so a still-held request is not replayed.
                    if (io_out_ready) begin
                        out_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    out_vld_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign io_in_ready                  = (state_q == IDLE);
    assign io_out_valid                 = out_vld_q;
    assign io_out_bits_result_quotient  = quo_out_q;
    assign io_out_bits_result_remainder = rem_out_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed bench for iter_div_unit: vector table plus flush, back-to-back, stall and reset sequences.
// Latency: checks exact result cycle (T+33, or T+1 for early-out cases when DIV_EARLY_OUT_EN).
// Backpressure: exercises io_out_ready low in DONE and held io_in_valid.
module tb_iter_div_unit;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_BUILD = 1'b1;
`else
    localparam bit EARLY_BUILD = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic        io_in_bits_ctrl_flow_div_signed;
    logic        io_in_bits_ctrl_flow_flush;
    logic [31:0] io_in_bits_ctrl_data_src1;
    logic [31:0] io_in_bits_ctrl_data_src2;
    logic        io_out_ready;
    logic        io_out_valid;
    logic [31:0] io_out_bits_result_quotient;
    logic [31:0] io_out_bits_result_remainder;

    int checks = 0;
    int errors = 0;

    iter_div_unit #(.WIDTH(32)) dut (
        .clock                           (clock),
        .reset                           (reset),
        .io_in_valid                     (io_in_valid),
        .io_in_ready                     (io_in_ready),
        .io_in_bits_ctrl_flow_div_signed (io_in_bits_ctrl_flow_div_signed),
        .io_in_bits_ctrl_flow_flush      (io_in_bits_ctrl_flow_flush),
        .io_in_bits_ctrl_data_src1       (io_in_bits_ctrl_data_src1),
        .io_in_bits_ctrl_data_src2       (io_in_bits_ctrl_data_src2),
        .io_out_ready                    (io_out_ready),
        .io_out_valid                    (io_out_valid),
        .io_out_bits_result_quotient     (io_out_bits_result_quotient),
        .io_out_bits_result_remainder    (io_out_bits_result_remainder)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        early;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present a request just after a negedge, keep it held until the result
    // appears, then drop it. lat = negedges from the request to io_out_valid (0 = timeout).
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] q, output logic [31:0] r);
        lat = 0;
        q   = '0;
        r   = '0;
        io_in_bits_ctrl_flow_div_signed = sgn;
        io_in_bits_ctrl_data_src1       = a;
        io_in_bits_ctrl_data_src2       = b;
        io_in_valid                     = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clock);
            if (io_out_valid) begin
                lat = n;
                q   = io_out_bits_result_quotient;
                r   = io_out_bits_result_remainder;
                break;
            end
        end
        io_in_valid = 1'b0;
    endtask

    int          lat;
    int          exp_lat;
    int          pulses;
    int          p1;
    int          p2;
    logic [31:0] q;
    logic [31:0] r;

    initial begin
        //             sgn   src1          src2          quotient      remainder     early
        vecs[0]  = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
        vecs[4]  = '{1'b0, 32'd20,       32'd3,        32'd6,        32'd2,        1'b0};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
        vecs[6]  = '{1'b0, 32'h80000001, 32'h80000000, 32'd1,        32'd1,        1'b0};
        vecs[7]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
        vecs[8]  = '{1'b1, 32'hFFFFFFF8, 32'd2,        32'hFFFFFFFC, 32'd0,        1'b0};
        vecs[9]  = '{1'b0, 32'd3,        32'd5,        32'd0,        32'd3,        1'b1};
        vecs[10] = '{1'b0, 32'd0,        32'd0,        32'hFFFFFFFF, 32'd0,        1'b1};
        vecs[11] = '{1'b1, 32'hFFFFFFFA, 32'hFFFFFFFC, 32'd1,        32'hFFFFFFFE, 1'b0};
        vecs[12] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        32'd1,        1'b0};
        vecs[13] = '{1'b1, 32'hFFFFFFFF, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};

        reset                           = 1'b0;
        io_in_valid                     = 1'b0;
        io_in_bits_ctrl_flow_div_signed = 1'b0;
        io_in_bits_ctrl_flow_flush      = 1'b0;
        io_in_bits_ctrl_data_src1       = '0;
        io_in_bits_ctrl_data_src2       = '0;
        io_out_ready                    = 1'b1;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_out_valid", {31'd0, io_out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, io_in_ready},  32'd1);
        check("rst_quotient",  io_out_bits_result_quotient,  32'd0);
        check("rst_remainder", io_out_bits_result_remainder, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Vector table: result, latency, one-cycle pulse, ready again afterwards
        for (int i = 0; i < NVEC; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, q, r);
            exp_lat = (EARLY_BUILD && vecs[i].early) ? 1 : 33;
            check($sformatf("v%0d_latency", i), lat, exp_lat);
            check($sformatf("v%0d_quotient", i), q, vecs[i].q);
            check($sformatf("v%0d_remainder", i), r, vecs[i].r);
            @(negedge clock);
            check($sformatf("v%0d_pulse_end", i), {31'd0, io_out_valid}, 32'd0);
            check($sformatf("v%0d_ready_after", i), {31'd0, io_in_ready}, 32'd1);
        end

        // Flush together with a request in IDLE must not accept
        io_in_bits_ctrl_flow_div_signed = 1'b0;
        io_in_bits_ctrl_data_src1       = 32'd20;
        io_in_bits_ctrl_data_src2       = 32'd3;
        io_in_valid                     = 1'b1;
        io_in_bits_ctrl_flow_flush      = 1'b1;
        @(negedge clock);
        check("idle_flush_ready0", {31'd0, io_in_ready}, 32'd1);
        @(negedge clock);
        check("idle_flush_ready1", {31'd0, io_in_ready}, 32'd1);
        io_in_valid                = 1'b0;
        io_in_bits_ctrl_flow_flush = 1'b0;
        @(negedge clock);

        // Flush in BUSY at cnt==10, then no result ever appears
        io_in_bits_ctrl_data_src1 = 32'd100;
        io_in_bits_ctrl_data_src2 = 32'd7;
        io_in_valid               = 1'b1;
        repeat (11) @(negedge clock);
        check("busy_before_flush", {31'd0, io_in_ready}, 32'd0);
        io_in_valid                = 1'b0;
        io_in_bits_ctrl_flow_flush = 1'b1;
        @(negedge clock);
        io_in_bits_ctrl_flow_flush = 1'b0;
        check("flush_idle", {31'd0, io_in_ready}, 32'd1);
        check("flush_no_valid", {31'd0, io_out_valid}, 32'd0);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (io_out_valid) pulses++;
        end
        check("flush_silent", pulses, 0);
        run_div(1'b0, 32'd20, 32'd3, lat, q, r);
        check("post_flush_latency", lat, 33);
        check("post_flush_quotient", q, 32'd6);
        check("post_flush_remainder", r, 32'd2);
        @(negedge clock);

        // Back-to-back with valid held continuously: exactly two pulses
        io_in_bits_ctrl_flow_div_signed = 1'b0;
        io_in_bits_ctrl_data_src1       = 32'd100;
        io_in_bits_ctrl_data_src2       = 32'd7;
        io_in_valid                     = 1'b1;
        pulses = 0;
        p1     = 0;
        p2     = 0;
        for (int n = 1; n <= 110; n++) begin
            @(negedge clock);
            if (io_out_valid) begin
                pulses++;
                if (pulses == 1) p1 = n;
                if (pulses == 2) begin
                    p2 = n;
                    io_in_valid = 1'b0;
                    check("b2b_second_quotient", io_out_bits_result_quotient, 32'd14);
                end
            end
        end
        check("b2b_pulses", pulses, 2);
        check("b2b_first_at", p1, 33);
        check("b2b_second_at", p2, 67);

        // Consumer stall in DONE: result and valid held
        io_out_ready = 1'b0;
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, lat, q, r);
        check("stall_latency", lat, 33);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("stall%0d_valid", k), {31'd0, io_out_valid}, 32'd1);
            check($sformatf("stall%0d_quotient", k), io_out_bits_result_quotient, 32'hFFFFFFFD);
            check($sformatf("stall%0d_remainder", k), io_out_bits_result_remainder, 32'hFFFFFFFF);
            check($sformatf("stall%0d_in_ready", k), {31'd0, io_in_ready}, 32'd0);
        end
        io_out_ready = 1'b1;
        @(negedge clock);
        check("stall_release", {31'd0, io_out_valid}, 32'd0);

        // Asynchronous reset mid-BUSY clears state without a clock edge
        io_in_bits_ctrl_flow_div_signed = 1'b0;
        io_in_bits_ctrl_data_src1       = 32'd100;
        io_in_bits_ctrl_data_src2       = 32'd7;
        io_in_valid                     = 1'b1;
        repeat (10) @(negedge clock);
        io_in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("arst_in_ready",  {31'd0, io_in_ready},  32'd1);
        check("arst_out_valid", {31'd0, io_out_valid}, 32'd0);
        check("arst_quotient",  io_out_bits_result_quotient,  32'd0);
        check("arst_remainder", io_out_bits_result_remainder, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_div(1'b0, 32'd100, 32'd7, lat, q, r);
        check("post_rst_latency", lat, 33);
        check("post_rst_quotient", q, 32'd14);
        check("post_rst_remainder", r, 32'd2);
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
